lsu_mem_lane_serializer: RTL
============================

Name: lsu_mem_lane_serializer

Overview:
- Sits between the LSU multi-lane memory port and a single-lane memory port, for example a narrow local-memory or uncached path.
- Accepts one NUM_LANES-wide request and issues its active lanes one per cycle downstream.
- For reads, collects per-lane responses (in any order) and returns one reassembled multi-lane response carrying the original tag.
- Holds one multi-lane request in flight at a time.

Parameters:
- NUM_LANES, 4, lanes per upstream request.
- DATA_SIZE, 4, bytes per lane.
- ADDR_WIDTH, 30, per-lane word address width.
- ATYPE_WIDTH, 2, per-lane address-type width.
- BANK_SEL_BITS, 1, per-lane cache-select width.
- TAG_WIDTH, 8, upstream tag width.
- LANE_BITS, max(clog2(NUM_LANES),1), derived; downstream tag width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_req_valid  in  1  upstream request valid
- in_req_rw  in  1  1=write, 0=read
- in_req_mask  in  NUM_LANES  active lanes
- in_req_byteen  in  NUM_LANES*DATA_SIZE  per-lane byte enables
- in_req_addr  in  NUM_LANES*ADDR_WIDTH  per-lane addresses
- in_req_atype  in  NUM_LANES*ATYPE_WIDTH  per-lane address type
- in_req_spatial  in  NUM_LANES  per-lane spatial hint
- in_req_cache_sel  in  NUM_LANES*BANK_SEL_BITS  per-lane bank select
- in_req_data  in  NUM_LANES*DATA_SIZE*8  write data
- in_req_tag  in  TAG_WIDTH  request tag
- in_req_ready  out  1  request accepted
- in_rsp_valid  out  1  reassembled read response valid
- in_rsp_mask  out  NUM_LANES  captured request mask
- in_rsp_data  out  NUM_LANES*DATA_SIZE*8  read data, lane-ordered
- in_rsp_tag  out  TAG_WIDTH  captured request tag
- in_rsp_ready  in  1  upstream accepts response
- out_req_valid, out_req_rw, out_req_byteen[DATA_SIZE], out_req_addr[ADDR_WIDTH], out_req_atype[ATYPE_WIDTH], out_req_spatial[1], out_req_cache_sel[BANK_SEL_BITS], out_req_data[DATA_SIZE*8]  out  single-lane request fields
- out_req_tag  out  LANE_BITS  lane index of the issued lane
- out_req_ready  in  1  downstream accepts
- out_rsp_valid  in  1  downstream response valid
- out_rsp_data  in  DATA_SIZE*8  response data
- out_rsp_tag  in  LANE_BITS  lane index
- out_rsp_ready  out  1  response accepted

Behaviour:
- Reset (async, reset_n=0): state IDLE; all captured registers and the pending/received masks cleared. out_req_valid=0, in_rsp_valid=0, out_rsp_ready=0, in_req_ready=1.
- States: IDLE, ISSUE, WAIT, RSP.
- in_req_ready = (state==IDLE).
- out_rsp_ready = (state==ISSUE or WAIT).
- in_rsp_valid = (state==RSP).
- IDLE:
  - On in_req_valid, capture all request fields and set issue_mask = in_req_mask.
  - Reads: set rcv_pending = in_req_mask and clear data_buf.
  - mask nonzero -> ISSUE. mask==0 and read -> RSP (zero data). mask==0 and write -> IDLE (dropped, no response).
- ISSUE:
  - out_req_valid=1; fields come from the lowest set bit of issue_mask; out_req_tag = that lane index.
  - On out_req_ready, clear that bit.
  - When the last bit clears: write -> IDLE (writes produce no upstream response); read -> WAIT, or RSP if rcv_pending is already 0.
- Responses are accepted in ISSUE and WAIT:
  - On out_rsp_valid, write data_buf[out_rsp_tag] and clear rcv_pending[out_rsp_tag].
  - Responses may arrive in any order, including before later lanes issue.
  - A response whose tag is not pending is ignored (simulation assertion).
- WAIT: when rcv_pending becomes 0 -> RSP next cycle.
- RSP:
  - Outputs are held stable until in_rsp_ready, then -> IDLE.
  - in_rsp_data lanes not in the mask are 0.
- Ordering: lanes issue in ascending index order; one issue per cycle maximum.
- Latency:
  - Accept at cycle T gives the first out_req_valid at T+1.
  - Full throughput: a k-lane write takes k cycles after accept.
  - A read's in_rsp_valid asserts the cycle after the last response handshake.
- Simultaneous events: the final issue handshake and the final response in the same cycle -> RSP directly. A response handshake for a lane issued in that same cycle is legal only at the next cycle or later.
- No new request is accepted until the cycle after in_rsp handshake (read) or final issue (write).
- Reset mid-operation aborts everything; downstream responses arriving after reset are not accepted because out_rsp_ready=0 in IDLE.

Test Plan:
- Read, mask=4'b1011, tag=8'h5A, addr lanes {0x10,0x11,0x12,0x13}, out_req_ready=1, responses in order -> out_req_tag sequence 0,1,3; in_rsp_valid with mask 1011, data lane2=0, tag 5A.
- Read, mask=4'b1111, responses returned in tag order 3,0,2,1 with data 0xD3,0xD0,0xD2,0xD1 -> in_rsp_data lanes {0xD0,0xD1,0xD2,0xD3}, one cycle after the last response.
- Write, mask=4'b0110, out_req_ready toggling 1,0,1 -> lane1 issued at cycle 1, lane2 issued at cycle 3, fields stable while stalled; no in_rsp_valid; in_req_ready=1 at cycle 4.
- Read, mask=0, tag=8'h07 -> no out_req_valid; in_rsp_valid the next cycle with data 0; with in_rsp_ready=0 for 3 cycles, outputs stay stable.
- Single lane read, response in the cycle after the issue handshake, then back-to-back second request -> second request is accepted in the cycle following the in_rsp handshake.
- Assert reset_n=0 in WAIT with 2 of 4 responses outstanding -> all valids 0 immediately, in_req_ready=1 after release; a new read then completes normally.

Source files
------------

// File: rtl/lsu_mem_lane_serializer.sv
// Serializes one multi-lane LSU request onto a single-lane memory port, one active lane per cycle,
// and reassembles per-lane read responses (any order) into one multi-lane response with the original tag.

module lsu_mem_lane_serializer_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          wr,
  input  logic          keep,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (wr)   q <= wr_data;
  end

  assign rd_data = keep ? q : '0;
endmodule

module lsu_mem_lane_serializer #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_SIZE     = 4,
  parameter int ADDR_WIDTH    = 30,
  parameter int ATYPE_WIDTH   = 2,
  parameter int BANK_SEL_BITS = 1,
  parameter int TAG_WIDTH     = 8,
  parameter int LANE_BITS     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 in_req_valid,
  input  logic                                 in_req_rw,
  input  logic [NUM_LANES-1:0]                 in_req_mask,
  input  logic [NUM_LANES*DATA_SIZE-1:0]       in_req_byteen,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]      in_req_addr,
  input  logic [NUM_LANES*ATYPE_WIDTH-1:0]     in_req_atype,
  input  logic [NUM_LANES-1:0]                 in_req_spatial,
  input  logic [NUM_LANES*BANK_SEL_BITS-1:0]   in_req_cache_sel,
  input  logic [NUM_LANES*DATA_SIZE*8-1:0]     in_req_data,
  input  logic [TAG_WIDTH-1:0]                 in_req_tag,
  output logic                                 in_req_ready,
  output logic                                 in_rsp_valid,
  output logic [NUM_LANES-1:0]                 in_rsp_mask,
  output logic [NUM_LANES*DATA_SIZE*8-1:0]     in_rsp_data,
  output logic [TAG_WIDTH-1:0]                 in_rsp_tag,
  input  logic                                 in_rsp_ready,
  output logic                                 out_req_valid,
  output logic                                 out_req_rw,
  output logic [DATA_SIZE-1:0]                 out_req_byteen,
  output logic [ADDR_WIDTH-1:0]                out_req_addr,
  output logic [ATYPE_WIDTH-1:0]               out_req_atype,
  output logic                                 out_req_spatial,
  output logic [BANK_SEL_BITS-1:0]             out_req_cache_sel,
  output logic [DATA_SIZE*8-1:0]               out_req_data,
  output logic [LANE_BITS-1:0]                 out_req_tag,
  input  logic                                 out_req_ready,
  input  logic                                 out_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]               out_rsp_data,
  input  logic [LANE_BITS-1:0]                 out_rsp_tag,
  output logic                                 out_rsp_ready
);
  localparam int DW = DATA_SIZE * 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;
  state_t state, state_n;

  logic                                     rw_q;
  logic [TAG_WIDTH-1:0]                     tag_q;
  logic [NUM_LANES-1:0]                     mask_q, spatial_q, issue_mask, rcv_pending;
  logic [NUM_LANES-1:0][DATA_SIZE-1:0]      byteen_q;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]     addr_q;
  logic [NUM_LANES-1:0][ATYPE_WIDTH-1:0]    atype_q;
  logic [NUM_LANES-1:0][BANK_SEL_BITS-1:0]  cache_sel_q;
  logic [NUM_LANES-1:0][DW-1:0]             data_q, rsp_data_w;

  logic [LANE_BITS-1:0] lane_idx;
  logic [NUM_LANES-1:0] rsp_sel, issue_left, rcv_left;
  logic                 accept, issue_fire, rsp_fire, rsp_hit, tag_ok;

  // Lowest pending lane wins, giving ascending issue order.
  always_comb begin
    lane_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (issue_mask[i]) lane_idx = LANE_BITS'(i);
  end

  assign accept     = in_req_valid & in_req_ready;
  assign issue_fire = out_req_valid & out_req_ready;
  assign rsp_fire   = out_rsp_valid & out_rsp_ready;
  assign tag_ok     = {1'b0, out_rsp_tag} < (LANE_BITS + 1)'(NUM_LANES);
  assign rsp_sel    = tag_ok ? (NUM_LANES'(1) << out_rsp_tag) : '0;
  // Responses for lanes no longer pending are dropped rather than corrupting data_buf.
  assign rsp_hit    = rsp_fire & |(rsp_sel & rcv_pending);
  assign issue_left = issue_fire ? (issue_mask & ~(NUM_LANES'(1) << lane_idx)) : issue_mask;
  assign rcv_left   = rsp_hit ? (rcv_pending & ~rsp_sel) : rcv_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n       = state;
    in_req_ready  = 1'b0;
    out_req_valid = 1'b0;
    out_rsp_ready = 1'b0;
    in_rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_req_ready = 1'b1;
        if (in_req_valid) begin
          if (|in_req_mask)    state_n = ISSUE;
          else if (!in_req_rw) state_n = RSP;
        end
      end
      ISSUE: begin
        out_req_valid = 1'b1;
        out_rsp_ready = 1'b1;
        // Using rcv_left lets a final response coinciding with the final issue go straight to RSP.
        if (issue_fire && issue_left == '0)
          state_n = rw_q ? IDLE : ((rcv_left == '0) ? RSP : WAIT);
      end
      WAIT: begin
        out_rsp_ready = 1'b1;
        if (rcv_left == '0) state_n = RSP;
      end
      RSP: begin
        in_rsp_valid = 1'b1;
        if (in_rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q        <= 1'b0;
      tag_q       <= '0;
      mask_q      <= '0;
      spatial_q   <= '0;
      byteen_q    <= '0;
      addr_q      <= '0;
      atype_q     <= '0;
      cache_sel_q <= '0;
      data_q      <= '0;
      issue_mask  <= '0;
      rcv_pending <= '0;
    end else begin
      if (accept) begin
        rw_q        <= in_req_rw;
        tag_q       <= in_req_tag;
        mask_q      <= in_req_mask;
        spatial_q   <= in_req_spatial;
        byteen_q    <= in_req_byteen;
        addr_q      <= in_req_addr;
        atype_q     <= in_req_atype;
        cache_sel_q <= in_req_cache_sel;
        data_q      <= in_req_data;
      end
      issue_mask  <= accept ? in_req_mask : issue_left;
      rcv_pending <= accept ? (in_req_rw ? '0 : in_req_mask) : rcv_left;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_mem_lane_serializer_lane #(.DW(DW)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (accept & ~in_req_rw),
      .wr      (rsp_hit & rsp_sel[i]),
      .keep    (mask_q[i]),
      .wr_data (out_rsp_data),
      .rd_data (rsp_data_w[i])
    );
  end

  assign out_req_rw        = rw_q;
  assign out_req_byteen    = byteen_q[lane_idx];
  assign out_req_addr      = addr_q[lane_idx];
  assign out_req_atype     = atype_q[lane_idx];
  assign out_req_spatial   = spatial_q[lane_idx];
  assign out_req_cache_sel = cache_sel_q[lane_idx];
  assign out_req_data      = data_q[lane_idx];
  assign out_req_tag       = lane_idx;
  assign in_rsp_mask       = mask_q;
  assign in_rsp_tag        = tag_q;
  assign in_rsp_data       = rsp_data_w;

  a_rsp_pending: assert property (@(posedge clk) disable iff (!reset_n) rsp_fire |-> rsp_hit);
endmodule
